fp_mul_result_buffer: RTL and testbench
=======================================

Name: fp_mul_result_buffer

Overview:
- Downstream stage of the FP32 multiply unit.
- Accepts each product with its status flags and tag, buffers it in a small FIFO, and applies backpressure to the multiplier through its out_ready input.
- Presents results to the consumer over a valid/ready interface.
- Keeps sticky IEEE exception flags and a count of delivered results for software visibility.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- TAG_WIDTH, 1, width of the tag carried alongside each result.
- CNT_WIDTH, 32, width of the delivered-result counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- mul_result_i  input  32  FP32 product from the multiplier.
- mul_status_i  input  5  multiplier status {NV,DZ,OF,UF,NX}.
- mul_tag_i  input  TAG_WIDTH  tag from the multiplier.
- mul_valid_i  input  1  multiplier output valid.
- mul_ready_o  output  1  buffer can accept; drives the multiplier out_ready.
- out_result_o  output  32  head-of-FIFO result.
- out_status_o  output  5  head-of-FIFO status.
- out_tag_o  output  TAG_WIDTH  head-of-FIFO tag.
- out_valid_o  output  1  head entry valid.
- out_ready_i  input  1  consumer accepts head entry.
- flush_i  input  1  synchronous flush; discards all buffered entries.
- fflags_clr_i  input  1  clears the sticky flags.
- fflags_o  output  5  sticky OR of the status of every accepted result.
- occupancy_o  output  $clog2(DEPTH)+1  number of entries held.
- result_cnt_o  output  CNT_WIDTH  results delivered to the consumer; wraps.

Behaviour:
- Reset (async assert, sync release):
  - rd/wr pointers, occupancy_o, fflags_o and result_cnt_o all go to 0.
  - out_valid_o=0, mul_ready_o=1.
  - Storage contents are don't-care.
  - Reset mid-stream drops all held entries; no output after release until a new push.
- Push: mul_valid_i && mul_ready_o. Writes {result,status,tag} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Pop: out_valid_o && out_ready_i. Advances rd_ptr modulo DEPTH and increments result_cnt_o (wraps 2^CNT_WIDTH-1 -> 0).
- mul_ready_o = (occupancy < DEPTH), from registered state only. No combinational path from out_ready_i or mul_valid_i.
  - When full, a same-cycle pop does not enable a push; ready rises the next cycle.
- out_valid_o = (occupancy != 0). Outputs are first-word-fall-through from storage. No bypass: a push into an empty buffer gives out_valid_o=1 one cycle later.
- Occupancy update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged, and both pointers advance.
- Ordering is strict FIFO; tags are never reordered or inspected.
- Output stability: while out_valid_o=1 and out_ready_i=0, out_result_o, out_status_o and out_tag_o hold stable.
- Flush, on the cycle after flush_i=1:
  - pointers and occupancy are 0.
  - any push or pop in the flush cycle is ignored; result_cnt_o does not increment.
  - fflags_o is unchanged by flush.
- Sticky flags:
  - On each push, fflags_o |= mul_status_i.
  - fflags_clr_i alone: fflags_o <= 0.
  - fflags_clr_i with a push in the same cycle: fflags_o <= mul_status_i (clear takes effect first).
  - fflags_clr_i with flush_i: flags clear; there is no push.
- The multiplier runs with zero pipeline registers, so mul_valid_i may be asserted every cycle. Sustained throughput is 1 result/cycle whenever out_ready_i stays high.

Test Plan:
- Reset release, then push 0x40C00000 (status 0, tag 1) -> out_valid_o=1 exactly one cycle later; out_result_o=0x40C00000, out_tag_o=1; pop gives result_cnt_o=1, occupancy_o=0.
- Hold out_ready_i=0 and push 5 results with DEPTH=4:
  - after 4 pushes mul_ready_o=0 and occupancy_o=4; the 5th is stalled with mul_valid_i held.
  - one pop -> mul_ready_o=1 on the following cycle; the 5th then enters.
  - drain order equals push order.
- Continuous push and pop for 20 cycles starting at occupancy 2 -> occupancy_o stays 2, result_cnt_o increases by 20, pointers wrap correctly with no data corruption.
- Push statuses 5'b00001, then 5'b10000 -> fflags_o=5'b10001. Then fflags_clr_i together with a push of status 5'b00100 -> fflags_o=5'b00100.
- With 3 entries held, assert flush_i together with mul_valid_i=1 -> next cycle occupancy_o=0 and out_valid_o=0; the pushed entry is dropped; fflags_o and result_cnt_o are unchanged.
- Assert rst_ni=0 asynchronously mid-cycle with 2 entries held -> outputs go to reset values immediately, before the next clock edge; after release out_valid_o=0, result_cnt_o=0, fflags_o=0.

Source files
------------

// File: rtl/fp_mul_result_buffer.sv
// Result buffer behind the FP32 multiplier: a small FIFO with backpressure, sticky IEEE
// exception flags and a delivered-result counter.
module fp_mul_result_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TAG_WIDTH = 1,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [31:0]              mul_result_i,
  input  logic [4:0]               mul_status_i,
  input  logic [TAG_WIDTH-1:0]     mul_tag_i,
  input  logic                     mul_valid_i,
  output logic                     mul_ready_o,
  output logic [31:0]              out_result_o,
  output logic [4:0]               out_status_o,
  output logic [TAG_WIDTH-1:0]     out_tag_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  input  logic                     flush_i,
  input  logic                     fflags_clr_i,
  output logic [4:0]               fflags_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic [CNT_WIDTH-1:0]     result_cnt_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;

  typedef struct packed {
    logic [31:0]          result;
    logic [4:0]           status;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  entry_t               mem_q [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]      occ_q, occ_d;
  logic [4:0]           fflags_q, fflags_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 push, pop;
  entry_t               head;

  // Handshakes depend only on registered occupancy, so a pop never frees a slot same-cycle.
  assign mul_ready_o = occ_q < OccW'(DEPTH);
  assign out_valid_o = occ_q != '0;
  assign push        = mul_valid_i && mul_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    fflags_d = fflags_clr_i ? 5'b0 : fflags_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        // Pointer width equals log2(DEPTH), so the increment wraps modulo DEPTH.
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        fflags_d = fflags_d | mul_status_i;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
        cnt_d    = cnt_q + CNT_WIDTH'(1);
      end
      unique case ({push, pop})
        2'b10:   occ_d = occ_q + OccW'(1);
        2'b01:   occ_d = occ_q - OccW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      fflags_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      fflags_q <= fflags_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; validity is tracked by occupancy alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{result: mul_result_i, status: mul_status_i, tag: mul_tag_i};
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign out_result_o = head.result;
  assign out_status_o = head.status;
  assign out_tag_o    = head.tag;
  assign fflags_o     = fflags_q;
  assign occupancy_o  = occ_q;
  assign result_cnt_o = cnt_q;

endmodule

// File: tb/tb_fp_mul_result_buffer.sv
// Scoreboard bench for fp_mul_result_buffer: a queue model of the FIFO, flags and counter is
// advanced every cycle and compared against the DUT at the falling edge.
module tb_fp_mul_result_buffer;

  localparam int unsigned Depth = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] mul_result_i;
  logic [4:0]  mul_status_i;
  logic [0:0]  mul_tag_i;
  logic        mul_valid_i;
  logic        mul_ready_o;
  logic [31:0] out_result_o;
  logic [4:0]  out_status_o;
  logic [0:0]  out_tag_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        flush_i;
  logic        fflags_clr_i;
  logic [4:0]  fflags_o;
  logic [2:0]  occupancy_o;
  logic [31:0] result_cnt_o;

  fp_mul_result_buffer #(
    .DEPTH     (Depth),
    .TAG_WIDTH (1),
    .CNT_WIDTH (32)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .mul_result_i (mul_result_i),
    .mul_status_i (mul_status_i),
    .mul_tag_i    (mul_tag_i),
    .mul_valid_i  (mul_valid_i),
    .mul_ready_o  (mul_ready_o),
    .out_result_o (out_result_o),
    .out_status_o (out_status_o),
    .out_tag_o    (out_tag_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .flush_i      (flush_i),
    .fflags_clr_i (fflags_clr_i),
    .fflags_o     (fflags_o),
    .occupancy_o  (occupancy_o),
    .result_cnt_o (result_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  logic [37:0] sb_q [$];  // {result, status, tag}
  logic [4:0]  exp_flags;
  logic [31:0] exp_cnt;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: compare at negedge, advance the model, return 1ns after posedge.
  task automatic step();
    logic        push, pop;
    logic [37:0] head;
    @(negedge clk_i);
    check("occupancy", 64'(occupancy_o), 64'(sb_q.size()));
    check("out_valid", 64'(out_valid_o), 64'(sb_q.size() != 0));
    check("mul_ready", 64'(mul_ready_o), 64'(sb_q.size() < Depth));
    check("fflags", 64'(fflags_o), 64'(exp_flags));
    check("result_cnt", 64'(result_cnt_o), 64'(exp_cnt));
    push = mul_valid_i && (sb_q.size() < Depth) && !flush_i;
    pop  = out_ready_i && (sb_q.size() != 0) && !flush_i;
    if (flush_i) begin
      sb_q.delete();
      if (fflags_clr_i) exp_flags = '0;
    end else begin
      if (fflags_clr_i) exp_flags = '0;
      if (pop) begin
        head = sb_q.pop_front();
        check("head_data", {26'd0, out_result_o, out_status_o, out_tag_o}, 64'(head));
        exp_cnt++;
      end
      if (push) begin
        exp_flags |= mul_status_i;
        sb_q.push_back({mul_result_i, mul_status_i, mul_tag_i});
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] s, input logic t);
    mul_valid_i  = v;
    mul_result_i = r;
    mul_status_i = s;
    mul_tag_i    = t;
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    for (int i = 0; i < 16 && sb_q.size() != 0; i++) step();
    check("drain_done", 64'(occupancy_o), 64'd0);
    out_ready_i = 1'b0;
  endtask

  logic [31:0] cnt_before;

  initial begin
    rst_ni = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    out_ready_i = 1'b0; flush_i = 1'b0; fflags_clr_i = 1'b0;
    exp_flags = '0; exp_cnt = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    step();

    // Single push: no bypass, valid one cycle later.
    drive(1'b1, 32'h40C0_0000, 5'd0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    check("lat_valid", 64'(out_valid_o), 64'd1);
    check("lat_result", 64'(out_result_o), 64'h40C0_0000);
    check("lat_tag", 64'(out_tag_o), 64'd1);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    check("pop_cnt", 64'(result_cnt_o), 64'd1);
    check("pop_occ", 64'(occupancy_o), 64'd0);

    // Fill to full; the fifth push stalls with valid held.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h1000_0000 + 32'(i), 5'd0, 1'(i));
      step();
    end
    check("full_ready", 64'(mul_ready_o), 64'd0);
    check("full_occ", 64'(occupancy_o), 64'd4);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    check("ready_after_pop", 64'(mul_ready_o), 64'd1);
    check("occ_after_pop", 64'(occupancy_o), 64'd3);
    step();
    drive(1'b0, '0, '0, 1'b0);
    check("fifth_in", 64'(occupancy_o), 64'd4);
    drain();

    // Streaming at occupancy 2 for 20 cycles.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, $urandom, 5'd0, 1'($urandom));
      step();
    end
    cnt_before = result_cnt_o;
    out_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, $urandom, 5'd0, 1'($urandom));
      step();
    end
    drive(1'b0, '0, '0, 1'b0);
    out_ready_i = 1'b0;
    check("stream_occ", 64'(occupancy_o), 64'd2);
    check("stream_cnt", 64'(result_cnt_o - cnt_before), 64'd20);
    drain();

    // Sticky flags, then clear together with a push.
    drive(1'b1, 32'h3F80_0000, 5'b00001, 1'b0);
    step();
    drive(1'b1, 32'h7FC0_0000, 5'b10000, 1'b1);
    step();
    check("flags_or", 64'(fflags_o), 64'h11);
    fflags_clr_i = 1'b1;
    drive(1'b1, 32'h0000_0001, 5'b00100, 1'b0);
    step();
    fflags_clr_i = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    check("flags_clr_push", 64'(fflags_o), 64'h04);
    drain();

    // Flush with a concurrent push.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hA000_0000 + 32'(i), 5'd0, 1'(i));
      step();
    end
    cnt_before = result_cnt_o;
    flush_i = 1'b1;
    out_ready_i = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 5'b01000, 1'b1);
    step();
    flush_i = 1'b0;
    out_ready_i = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    check("flush_occ", 64'(occupancy_o), 64'd0);
    check("flush_valid", 64'(out_valid_o), 64'd0);
    check("flush_flags", 64'(fflags_o), 64'h04);
    check("flush_cnt", 64'(result_cnt_o), 64'(cnt_before));
    step();

    // Asynchronous reset mid-cycle with two entries held.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h5555_0000 + 32'(i), 5'b00010, 1'b1);
      step();
    end
    drive(1'b0, '0, '0, 1'b0);
    #1 rst_ni = 1'b0;
    #1;
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_occ", 64'(occupancy_o), 64'd0);
    check("rst_ready", 64'(mul_ready_o), 64'd1);
    check("rst_flags", 64'(fflags_o), 64'd0);
    check("rst_cnt", 64'(result_cnt_o), 64'd0);
    sb_q.delete();
    exp_flags = '0;
    exp_cnt = '0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    out_ready_i = 1'b1;
    repeat (3) step();
    check("post_rst_valid", 64'(out_valid_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
